// File: rtl/control_queue.sv
// control_queue: merges decoded UART keystrokes and button edges into a DEPTH-entry command FIFO.
// Optional auto-repeat of held buttons is compiled in when CONTROL_AUTOREPEAT_EN is defined.
package control_queue_pkg;
   typedef enum logic [2:0] {
      NONE       = 3'd0,
      LEFT       = 3'd1,
      RIGHT      = 3'd2,
      DOWN       = 3'd3,
      DROP       = 3'd4,
      HOLD       = 3'd5,
      ROTATE     = 3'd6,
      ROTATE_REV = 3'd7
   } control_type;
endpackage

module control_queue
   import control_queue_pkg::*;
#(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned REPEAT_DELAY = 25_000_000,
   parameter int unsigned REPEAT_RATE  = 5_000_000,
   parameter logic [3:0]  REPEAT_MASK  = 4'b1001
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         rx_valid,
   input  logic [7:0]                   rx_byte,
   input  logic [3:0]                   btn,
   input  logic                         flush,
   input  logic                         ready,
   output control_type                  control,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full,
   output logic [7:0]                   overflow_cnt
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   function automatic control_type decode(input logic [7:0] b);
      case (b)
         8'h41, 8'h61: decode = LEFT;
         8'h44, 8'h64: decode = RIGHT;
         8'h57, 8'h77: decode = DOWN;
         8'h53, 8'h73: decode = DROP;
         8'h43, 8'h63: decode = HOLD;
         8'h58, 8'h78: decode = ROTATE;
         8'h5A, 8'h7A: decode = ROTATE_REV;
         default:      decode = NONE;
      endcase
   endfunction

   function automatic control_type btn_cmd(input logic [3:0] onehot);
      case (onehot)
         4'b0001: btn_cmd = RIGHT;
         4'b0010: btn_cmd = HOLD;
         4'b0100: btn_cmd = ROTATE;
         4'b1000: btn_cmd = LEFT;
         default: btn_cmd = NONE;
      endcase
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   control_type     mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [3:0]      pend_q, pend_d, btn_q;
   logic [7:0]      ovf_q, ovf_d;
   logic [3:0]      rise, rep_fire, cand, win;
   control_type     uart_cmd, push_cmd;
   logic            uart_hit, push, pop, room;

   assign rise = btn & ~btn_q;
   assign cand = pend_q | rise | rep_fire;
   assign win  = cand & (~cand + 4'd1);

`ifdef CONTROL_AUTOREPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW = $clog2(RMAX + 1);

   // hold_q counts cycles since the press or the last repeat; rep_q selects delay vs. rate.
   for (genvar gi = 0; gi < 4; gi++) begin : g_rep
      if (REPEAT_MASK[gi]) begin : g_on
         logic [RW-1:0] hold_q, hold_d;
         logic          rep_q, rep_d, fire;

         always_comb begin
            fire   = btn[gi] && !rise[gi] &&
                     (rep_q ? (hold_q == RW'(REPEAT_RATE)) : (hold_q == RW'(REPEAT_DELAY)));
            hold_d = hold_q + RW'(1);
            rep_d  = rep_q;
            if (flush || !btn[gi]) begin
               hold_d = '0;
               rep_d  = 1'b0;
            end else if (rise[gi]) begin
               hold_d = RW'(1);
               rep_d  = 1'b0;
            end else if (fire) begin
               hold_d = RW'(1);
               rep_d  = 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               hold_q <= '0;
               rep_q  <= 1'b0;
            end else begin
               hold_q <= hold_d;
               rep_q  <= rep_d;
            end
         end

         assign rep_fire[gi] = fire;
      end else begin : g_off
         assign rep_fire[gi] = 1'b0;
      end
   end
`else
   assign rep_fire = 4'b0000;
`endif

   always_comb begin
      uart_cmd = decode(rx_byte);
      uart_hit = rx_valid && (uart_cmd != NONE);
      pop      = ready && (count_q != '0);
      room     = (count_q != CW'(DEPTH)) || pop;
      push     = 1'b0;
      push_cmd = NONE;
      pend_d   = cand;
      ovf_d    = ovf_q;
      // UART wins; a blocked button simply stays in the pending mask.
      if (uart_hit) begin
         if (room) begin
            push     = 1'b1;
            push_cmd = uart_cmd;
         end else if (ovf_q != 8'hFF) begin
            ovf_d = ovf_q + 8'd1;
         end
      end else if (room && (win != 4'd0)) begin
         push     = 1'b1;
         push_cmd = btn_cmd(win);
         pend_d   = cand & ~win;
      end
      if (flush) begin
         push   = 1'b0;
         pop    = 1'b0;
         pend_d = 4'd0;
         ovf_d  = ovf_q;
      end
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && push) begin
         mem_q[wr_ptr_q] <= push_cmd;
      end
   end

   always_ff @(posedge clk) begin
      btn_q <= btn;
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pend_q   <= 4'd0;
         ovf_q    <= 8'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
      end
   end

   assign empty        = (count_q == '0);
   assign full         = (count_q == CW'(DEPTH));
   assign count        = count_q;
   assign overflow_cnt = ovf_q;
   assign control      = empty ? NONE : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_control_queue.sv
// Bench for control_queue: directed scenarios then random traffic, checked against a queue-based model.
module tb_control_queue;
   import control_queue_pkg::*;

   localparam int         DEPTH = 4;
   localparam int         RD    = 10;
   localparam int         RR    = 4;
   localparam logic [3:0] RM    = 4'b1001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, rx_valid, flush, ready;
   logic [7:0]  rx_byte;
   logic [3:0]  btn;
   control_type control;
   logic [2:0]  count;
   logic        empty, full;
   logic [7:0]  overflow_cnt;

   control_queue #(
      .DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(RM)
   ) dut (
      .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .btn(btn), .flush(flush), .ready(ready), .control(control), .count(count),
      .empty(empty), .full(full), .overflow_cnt(overflow_cnt)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: a queue of commands plus the pending-button set.
   control_type mq[$];
   control_type keymap[logic [7:0]];
   control_type bmap[4] = '{RIGHT, HOLD, ROTATE, LEFT};
   logic [3:0]  m_pend, m_prev;
   int          m_ovf;
   int          m_held[4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [3:0] rise, fire, cand;
      bit room;
      if (!reset_n) begin
         mq.delete();
         m_pend = 4'd0;
         m_ovf  = 0;
         m_prev = btn;
         for (int i = 0; i < 4; i++) m_held[i] = -1;
         return;
      end
      rise = btn & ~m_prev;
      fire = 4'd0;
`ifdef CONTROL_AUTOREPEAT_EN
      // held cycles since the press; repeats at DELAY, DELAY+RATE, DELAY+2*RATE ...
      for (int i = 0; i < 4; i++) begin
         if (RM[i] && btn[i]) begin
            m_held[i] = rise[i] ? 0 : m_held[i] + 1;
            if (!rise[i] && m_held[i] >= RD && ((m_held[i] - RD) % RR) == 0) fire[i] = 1'b1;
         end else begin
            m_held[i] = 0;
         end
      end
`endif
      cand   = m_pend | rise | fire;
      m_prev = btn;
      if (flush) begin
         mq.delete();
         m_pend = 4'd0;
         for (int i = 0; i < 4; i++) m_held[i] = -1;
         return;
      end
      room = (mq.size() < DEPTH) || (ready && mq.size() > 0);
      if (ready && mq.size() > 0) void'(mq.pop_front());
      m_pend = cand;
      if (rx_valid && keymap.exists(rx_byte)) begin
         if (room) mq.push_back(keymap[rx_byte]);
         else if (m_ovf < 255) m_ovf++;
      end else if (room) begin
         for (int i = 0; i < 4; i++) begin
            if (cand[i]) begin
               mq.push_back(bmap[i]);
               m_pend[i] = 1'b0;
               break;
            end
         end
      end
   endtask

   task automatic check_outputs();
      control_type exp_ctl;
      exp_ctl = (mq.size() > 0) ? mq[0] : NONE;
      check("control", 32'(control), 32'(exp_ctl));
      check("count", 32'(count), 32'(mq.size()));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
   endtask

   task automatic cycle(input logic rv, input logic [7:0] rb, input logic [3:0] b,
                        input logic fl, input logic rdy);
      rx_valid = rv;
      rx_byte  = rb;
      btn      = b;
      flush    = fl;
      ready    = rdy;
      if (reset_n) check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      string keys;
      string pool;
      int    seen;
      logic [3:0] rb;
      keys = "adwscxz";
      for (int i = 0; i < keys.len(); i++) begin
         keymap[keys[i]]         = control_type'(i + 1);
         keymap[keys[i] - 8'd32] = control_type'(i + 1);
      end

      reset_n = 1'b0;
      cycle(0, 8'h00, 4'b0000, 0, 0);
      cycle(0, 8'h00, 4'b0000, 0, 0);
      reset_n = 1'b1;
      check("rst_control", 32'(control), 32'(NONE));
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_ovf", 32'(overflow_cnt), 0);

      // "a" then "X", then two pops
      cycle(1, "a", 4'b0000, 0, 0);
      cycle(1, "X", 4'b0000, 0, 0);
      check("ax_control", 32'(control), 32'(LEFT));
      check("ax_count", 32'(count), 2);
      cycle(0, 8'h00, 4'b0000, 0, 1);
      check("pop1_control", 32'(control), 32'(ROTATE));
      cycle(0, 8'h00, 4'b0000, 0, 1);
      check("pop2_control", 32'(control), 32'(NONE));
      check("pop2_empty", 32'(empty), 1);

      // UART plus three button edges in one cycle
      cycle(1, "s", 4'b1011, 0, 0);
      cycle(0, 8'h00, 4'b1011, 0, 0);
      cycle(0, 8'h00, 4'b1011, 0, 0);
      cycle(0, 8'h00, 4'b0000, 0, 0);
      check("arb_count", 32'(count), 4);
      check("arb_head", 32'(control), 32'(DROP));
      cycle(0, 8'h00, 4'b0000, 0, 1);
      check("arb_2nd", 32'(control), 32'(RIGHT));
      cycle(0, 8'h00, 4'b0000, 0, 1);
      check("arb_3rd", 32'(control), 32'(HOLD));
      cycle(0, 8'h00, 4'b0000, 0, 1);
      check("arb_4th", 32'(control), 32'(LEFT));
      cycle(0, 8'h00, 4'b0000, 0, 1);

      // Fill, drop a UART command, then a pending button enters on a pop
      for (int i = 0; i < 4; i++) cycle(1, "d", 4'b0000, 0, 0);
      cycle(1, "w", 4'b0000, 0, 0);
      check("drop_ovf", 32'(overflow_cnt), 1);
      check("drop_full", 32'(full), 1);
      cycle(0, 8'h00, 4'b0010, 0, 0);
      check("pend_count", 32'(count), 4);
      cycle(0, 8'h00, 4'b0010, 0, 1);
      check("pend_hold_count", 32'(count), 4);

      // Full with simultaneous pop and push
      cycle(1, "z", 4'b0000, 0, 1);
      check("fullpp_count", 32'(count), 4);
      for (int i = 0; i < 3; i++) cycle(0, 8'h00, 4'b0000, 0, 1);
      check("fullpp_last", 32'(control), 32'(ROTATE_REV));
      cycle(0, 8'h00, 4'b0000, 0, 1);
      check("fullpp_empty", 32'(empty), 1);

      // Flush with a UART command and a pending button
      for (int i = 0; i < 4; i++) cycle(1, "d", 4'b0000, 0, 0);
      cycle(0, 8'h00, 4'b0100, 0, 0);
      cycle(1, "c", 4'b0100, 1, 0);
      check("flush_count", 32'(count), 0);
      check("flush_control", 32'(control), 32'(NONE));
      check("flush_ovf", 32'(overflow_cnt), 1);
      for (int i = 0; i < 3; i++) cycle(0, 8'h00, 4'b0100, 0, 0);
      check("flush_after_count", 32'(count), 0);
      cycle(0, 8'h00, 4'b0000, 0, 0);

      // Held buttons: repeat-eligible btn[3] vs. non-eligible btn[1]
      seen = 0;
      for (int i = 0; i < 32; i++) begin
         cycle(0, 8'h00, (i < 30) ? 4'b1000 : 4'b0000, 0, 1);
         if (control == LEFT) seen++;
      end
`ifdef CONTROL_AUTOREPEAT_EN
      check("repeat_left_n", 32'(seen), 6);
`else
      check("repeat_left_n", 32'(seen), 1);
`endif
      seen = 0;
      for (int i = 0; i < 32; i++) begin
         cycle(0, 8'h00, (i < 30) ? 4'b0010 : 4'b0000, 0, 1);
         if (control == HOLD) seen++;
      end
      check("repeat_hold_n", 32'(seen), 1);

      // Overflow counter saturation
      for (int i = 0; i < 4; i++) cycle(1, "a", 4'b0000, 0, 0);
      for (int i = 0; i < 260; i++) cycle(1, "w", 4'b0000, 0, 0);
      check("ovf_sat", 32'(overflow_cnt), 255);
      cycle(0, 8'h00, 4'b0000, 1, 0);

      // Random traffic against the model
      pool = "aAdDwWsScCxXzZq1 ?";
      rb = 4'b0000;
      for (int i = 0; i < 1500; i++) begin
         logic [7:0] byt;
         if ($urandom_range(0, 3) == 0) byt = 8'($urandom);
         else byt = pool[$urandom_range(0, pool.len() - 1)];
         if ($urandom_range(0, 5) == 0) rb = 4'($urandom);
         reset_n = ($urandom_range(0, 299) != 0);
         cycle(($urandom_range(0, 2) == 0), byt, rb,
               ($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0));
         reset_n = 1'b1;
      end
      cycle(0, 8'h00, 4'b0000, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
